store_writer: RTL and testbench
===============================

# store_writer

Store-side memory controller for the RISC-V core, the write-direction counterpart of the writeback/load path. Takes a store from the execute stage and decodes its address into DMEM, IMEM and MMIO targets. Produces byte-lane write enables and lane-replicated data, and owns the UART TX holding register with its ready/valid handshake. Also holds the cycle and retired-instruction counters with their MMIO reset; raises a stall when a UART store cannot be accepted.

## Interface
- DWIDTH, 32: data and address width
- MEM_AW, 14: word-address width of DMEM/IMEM
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  a store instruction is in execute this cycle
- st_addr  in  32  byte address (ALU result)
- st_data  in  32  rs2 value
- st_funct3  in  3  000 SB, 001 SH, 010 SW; others illegal
- pc_top4  in  4  PC[31:28] of the store instruction
- inst_retire  in  1  one instruction retires this cycle
- stall  out  1  hold the pipeline; store not taken this cycle
- dmem_we / imem_we  out  4 each  byte-lane write enables
- dmem_addr / imem_addr  out  MEM_AW each  st_addr[MEM_AW+1:2]
- dmem_din / imem_din  out  32 each  lane-replicated store data
- uart_tx_data  out  8  byte to transmit
- uart_tx_valid  out  1  holding register full
- uart_tx_ready  in  1  UART accepts the byte this cycle
- cycle_cnt / inst_cnt  out  32 each  counters
- st_err  out  1  sticky illegal or misaligned store flag

## Operation
- Decode uses st_addr[31:28]:
  - 0001: DMEM
  - 0010: IMEM
  - 0011: both DMEM and IMEM
  - 1000: MMIO
  - anything else: no effect
- IMEM writes are enabled only when pc_top4 == 0100 (executing from BIOS). Otherwise imem_we = 0 and st_err is not set.
- Lanes and data (o = st_addr[1:0]):
  - SB: we = 0001 << o; din = {4{st_data[7:0]}}
  - SH: requires o[0] = 0; we = 0011 << o; din = {2{st_data[15:0]}}
  - SW: requires o = 00; we = 1111; din = st_data
- Misaligned store, or funct3 not in {000, 001, 010}: all we = 0, no MMIO side effect, st_err set.
- MMIO 0x80000008: UART TX write of st_data[7:0].
  - Accepted when tx_valid = 0, or tx_valid = 1 and uart_tx_ready = 1 (same-cycle replace).
  - Otherwise stall = 1 (combinational) until accepted.
- MMIO 0x80000018: counter reset. Both counters read 0 the next cycle; this overrides the increment that cycle.
- Other MMIO addresses: ignored.
- Counters:
  - cycle_cnt increments every cycle.
  - inst_cnt increments when inst_retire = 1.
  - Both wrap 0xFFFFFFFF -> 0.
- While stall = 1, all we = 0 and no state changes except the counters and the UART handshake.
- uart_tx_valid clears on the cycle it is consumed, unless it is refilled in that same cycle.

## Timing
- Reset: stall, all we, uart_tx_valid, st_err = 0; uart_tx_data = 0; both counters = 0; addr and din buses = 0.
- dmem/imem we, addr and din are combinational from inputs in the same cycle; the memory writes on the next clk edge.
- UART holding register: loaded at the clk edge of an accepted store; uart_tx_valid = 1 from the next cycle.
- Transfer occurs on any cycle with uart_tx_valid & uart_tx_ready.
- st_err: set at the edge after an illegal store; cleared only by rst.
- rst mid-handshake drops any pending TX byte.

## Structure
- Shared package (riscv_pkg): funct3 store codes, address-nibble constants (DMEM, IMEM, DMEM_IMEM, MMIO, BIOS_PC), MMIO addresses UART_TX_ADDR and CTR_RST_ADDR.
- Sub-module store_align: combinational funct3/offset -> 4-bit mask, replicated data, and misaligned flag.
- Top level holds decode, the TX register, the counters and st_err.

## Test plan
- SB to 0x10000003, data 0x000000AB -> dmem_we = 1000, dmem_din = 0xABABABAB; imem_we = 0.
- SW to 0x30000010, pc_top4 = 0100 -> dmem_we = imem_we = 1111, addr = 4.
- Same store with pc_top4 = 0001 -> imem_we = 0, dmem_we = 1111, st_err stays 0.
- SH to 0x10000001 -> all we = 0; st_err = 1 the next cycle and stays set until rst.
- Two back-to-back SB to 0x80000008 (0x41, 0x42) with uart_tx_ready = 0:
  - first accepted; stall = 1 on the second.
  - raise ready for one cycle -> 0x41 transferred and 0x42 loaded in the same cycle; stall drops.
- Run 100 cycles with inst_retire high half the time -> cycle_cnt = 100, inst_cnt = 50.
  - Then SW to 0x80000018 -> both counters = 0 the next cycle, then resume counting.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared store-path definitions: funct3 store encodings, address-region nibbles,
// MMIO register addresses and the region decoder used by the store writer.
package riscv_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] DMEM      = 4'b0001;
  localparam logic [3:0] IMEM      = 4'b0010;
  localparam logic [3:0] DMEM_IMEM = 4'b0011;
  localparam logic [3:0] MMIO      = 4'b1000;
  localparam logic [3:0] BIOS_PC   = 4'b0100;

  localparam logic [31:0] UART_TX_ADDR = 32'h8000_0008;
  localparam logic [31:0] CTR_RST_ADDR = 32'h8000_0018;

  typedef struct packed {
    logic dmem;
    logic imem;
    logic mmio;
  } target_t;

  function automatic target_t decode_target(input logic [3:0] nib);
    target_t t;
    t = '0;
    case (nib)
      DMEM:      t.dmem = 1'b1;
      IMEM:      t.imem = 1'b1;
      DMEM_IMEM: begin
        t.dmem = 1'b1;
        t.imem = 1'b1;
      end
      MMIO:      t.mmio = 1'b1;
      default:   t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane aligner: turns funct3 and the byte offset into a byte-lane mask,
// lane-replicated write data, and flags for misaligned or unknown store widths.
module store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    mask       = 4'b0000;
    wdata      = data;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        mask  = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        misaligned = offset[0];
        mask       = offset[0] ? 4'b0000 : (4'b0011 << offset);
        wdata      = {2{data[15:0]}};
      end
      F3_SW: begin
        misaligned = |offset;
        mask       = (|offset) ? 4'b0000 : 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_writer.sv
// Store-side memory controller: decodes execute-stage stores into DMEM/IMEM lane
// writes and MMIO side effects, and owns the UART TX holding register and counters.
module store_writer
  import riscv_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [DWIDTH-1:0] st_addr,
  input  logic [DWIDTH-1:0] st_data,
  input  logic [2:0]        st_funct3,
  input  logic [3:0]        pc_top4,
  input  logic              inst_retire,
  output logic              stall,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic [MEM_AW-1:0] imem_addr,
  output logic [DWIDTH-1:0] dmem_din,
  output logic [DWIDTH-1:0] imem_din,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  output logic [DWIDTH-1:0] cycle_cnt,
  output logic [DWIDTH-1:0] inst_cnt,
  output logic              st_err
);

  logic [3:0]        lane_mask;
  logic [DWIDTH-1:0] lane_data;
  logic              misaligned;
  logic              illegal_op;

  store_align u_align (
    .funct3     (st_funct3),
    .offset     (st_addr[1:0]),
    .data       (st_data),
    .mask       (lane_mask),
    .wdata      (lane_data),
    .misaligned (misaligned),
    .illegal    (illegal_op)
  );

  target_t tgt;
  logic    st_ok;
  logic    uart_hit;
  logic    ctr_hit;
  logic    tx_consume;
  logic    tx_block;
  logic    tx_accept;

  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic [DWIDTH-1:0] cycle_q,    cycle_d;
  logic [DWIDTH-1:0] inst_q,     inst_d;
  logic              err_q,      err_d;

  // A UART store blocks only when the holding register is full and not draining.
  always_comb begin
    tgt        = decode_target(st_addr[DWIDTH-1 -: 4]);
    st_ok      = st_valid && !misaligned && !illegal_op;
    uart_hit   = st_ok && tgt.mmio && (st_addr == UART_TX_ADDR);
    ctr_hit    = st_ok && tgt.mmio && (st_addr == CTR_RST_ADDR);
    tx_consume = tx_valid_q && uart_tx_ready;
    tx_block   = uart_hit && tx_valid_q && !uart_tx_ready;
    tx_accept  = uart_hit && !tx_block;
  end

  always_comb begin
    stall     = 1'b0;
    dmem_we   = 4'b0000;
    imem_we   = 4'b0000;
    dmem_addr = '0;
    imem_addr = '0;
    dmem_din  = '0;
    imem_din  = '0;
    if (!rst) begin
      stall     = tx_block;
      dmem_addr = st_addr[MEM_AW+1:2];
      imem_addr = st_addr[MEM_AW+1:2];
      dmem_din  = lane_data;
      imem_din  = lane_data;
      if (st_ok && !tx_block) begin
        if (tgt.dmem) dmem_we = lane_mask;
        // IMEM is writable only while running out of the BIOS region.
        if (tgt.imem && (pc_top4 == BIOS_PC)) imem_we = lane_mask;
      end
    end
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = st_data[7:0];
    end else if (tx_consume) begin
      tx_valid_d = 1'b0;
    end
    cycle_d = ctr_hit ? '0 : cycle_q + DWIDTH'(1);
    inst_d  = ctr_hit ? '0 : inst_q + DWIDTH'(inst_retire);
    err_d   = err_q | (st_valid && (misaligned || illegal_op));
  end

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      err_q      <= err_d;
    end
  end

  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign cycle_cnt     = cycle_q;
  assign inst_cnt      = inst_q;
  assign st_err        = err_q;

endmodule

// File: tb/tb_store_writer.sv
// Self-checking bench for store_writer: directed vector table, hand-written
// UART/counter/error sequences, and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_store_writer;

  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [DW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [2:0]    st_funct3;
  logic [3:0]    pc_top4;
  logic          inst_retire;
  logic          stall;
  logic [3:0]    dmem_we, imem_we;
  logic [AW-1:0] dmem_addr, imem_addr;
  logic [DW-1:0] dmem_din, imem_din;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_valid;
  logic          uart_tx_ready;
  logic [DW-1:0] cycle_cnt, inst_cnt;
  logic          st_err;

  always #5 clk = ~clk;

  store_writer #(.DWIDTH(DW), .MEM_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_funct3     (st_funct3),
    .pc_top4       (pc_top4),
    .inst_retire   (inst_retire),
    .stall         (stall),
    .dmem_we       (dmem_we),
    .imem_we       (imem_we),
    .dmem_addr     (dmem_addr),
    .imem_addr     (imem_addr),
    .dmem_din      (dmem_din),
    .imem_din      (imem_din),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .cycle_cnt     (cycle_cnt),
    .inst_cnt      (inst_cnt),
    .st_err        (st_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] pc);
    st_valid  = v;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    pc_top4   = pc;
  endtask

  task automatic idle();
    drive(1'b0, 3'b010, 32'h0, 32'h0, 4'h0);
  endtask

  // Returns at a falling edge with reset just released and all state cleared.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    uart_tx_ready = 1'b0;
    inst_retire   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [3:0]    pc;
    logic [3:0]    dwe;
    logic [3:0]    iwe;
    logic [AW-1:0] maddr;
    logic [31:0]   din;
  } vec_t;

  vec_t vecs[9];

  task automatic run_table();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].pc);
      #1;
      check($sformatf("vec%0d_dmem_we", i), 32'(dmem_we), 32'(vecs[i].dwe));
      check($sformatf("vec%0d_imem_we", i), 32'(imem_we), 32'(vecs[i].iwe));
      check($sformatf("vec%0d_dmem_addr", i), 32'(dmem_addr), 32'(vecs[i].maddr));
      check($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].maddr));
      check($sformatf("vec%0d_dmem_din", i), dmem_din, vecs[i].din);
      check($sformatf("vec%0d_imem_din", i), imem_din, vecs[i].din);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
    end
    @(negedge clk);
    idle();
    #1 check("table_no_err", 32'(st_err), 32'd0);
  endtask

  task automatic random_phase();
    logic        m_txv;
    logic [7:0]  m_txd;
    logic [31:0] m_cyc, m_inst;
    logic        m_err;
    logic        v, rdy, ret, bad, ok, is_uart, e_stall;
    logic [2:0]  f3;
    logic [31:0] a, d, e_din;
    logic [3:0]  pc, nib, mask, e_dwe, e_iwe;
    int          size, sel;
    do_reset();
    m_txv = 1'b0; m_txd = 8'h00; m_cyc = 32'd0; m_inst = 32'd0; m_err = 1'b0;
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 3)       a = {4'h1, 12'h000, 16'($urandom)};
      else if (sel < 5)  a = {4'h2, 12'h000, 16'($urandom)};
      else if (sel < 7)  a = {4'h3, 12'h000, 16'($urandom)};
      else if (sel < 8)  a = {4'($urandom_range(4, 7)), 28'($urandom)};
      else if (sel < 14) a = 32'h8000_0008;
      else if (sel < 15) a = 32'h8000_0018;
      else if (sel < 16) a = 32'h8000_0010;
      else               a = {4'h1, 12'h000, 16'($urandom)};
      f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      d   = $urandom;
      pc  = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      ret = 1'($urandom_range(0, 1));
      drive(v, f3, a, d, pc);
      uart_tx_ready = rdy;
      inst_retire   = ret;
      #1;
      size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      bad   = (size == 0) || ((int'(a[1:0]) % size) != 0);
      mask  = bad ? 4'd0 : 4'(((1 << size) - 1) << int'(a[1:0]));
      e_din = (size == 1) ? {24'd0, d[7:0]} * 32'h0101_0101 :
              (size == 2) ? {16'd0, d[15:0]} * 32'h0001_0001 : d;
      nib     = a[31:28];
      ok      = v && !bad;
      is_uart = ok && (a == 32'h8000_0008);
      e_stall = is_uart && m_txv && !rdy;
      e_dwe   = (ok && !e_stall && (nib == 4'd1 || nib == 4'd3)) ? mask : 4'd0;
      e_iwe   = (ok && !e_stall && (nib == 4'd2 || nib == 4'd3) && pc == 4'd4) ? mask : 4'd0;
      check("rnd_stall", 32'(stall), 32'(e_stall));
      check("rnd_dmem_we", 32'(dmem_we), 32'(e_dwe));
      check("rnd_imem_we", 32'(imem_we), 32'(e_iwe));
      check("rnd_tx_valid", 32'(uart_tx_valid), 32'(m_txv));
      check("rnd_tx_data", 32'(uart_tx_data), 32'(m_txd));
      check("rnd_cycle", cycle_cnt, m_cyc);
      check("rnd_inst", inst_cnt, m_inst);
      check("rnd_err", 32'(st_err), 32'(m_err));
      if (ok) begin
        check("rnd_dmem_addr", 32'(dmem_addr), (a >> 2) & 32'h3FFF);
        check("rnd_dmem_din", dmem_din, e_din);
      end
      if (is_uart && !e_stall) begin
        m_txv = 1'b1;
        m_txd = d[7:0];
      end else if (m_txv && rdy) begin
        m_txv = 1'b0;
      end
      if (ok && a == 32'h8000_0018) begin
        m_cyc  = 32'd0;
        m_inst = 32'd0;
      end else begin
        m_cyc  = m_cyc + 32'd1;
        m_inst = m_inst + 32'(ret);
      end
      if (v && bad) m_err = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b000, 32'h1000_0003, 32'h0000_00AB, 4'h0, 4'b1000, 4'b0000, 14'd0,      32'hABAB_ABAB};
    vecs[1] = '{3'b010, 32'h3000_0010, 32'hCAFE_F00D, 4'h4, 4'b1111, 4'b1111, 14'd4,      32'hCAFE_F00D};
    vecs[2] = '{3'b010, 32'h3000_0010, 32'hCAFE_F00D, 4'h1, 4'b1111, 4'b0000, 14'd4,      32'hCAFE_F00D};
    vecs[3] = '{3'b001, 32'h1000_0002, 32'h0000_1234, 4'h0, 4'b1100, 4'b0000, 14'd0,      32'h1234_1234};
    vecs[4] = '{3'b000, 32'h2000_0005, 32'h0000_0077, 4'h4, 4'b0000, 4'b0010, 14'd1,      32'h7777_7777};
    vecs[5] = '{3'b010, 32'h5000_0000, 32'h1122_3344, 4'h4, 4'b0000, 4'b0000, 14'd0,      32'h1122_3344};
    vecs[6] = '{3'b001, 32'h3000_0100, 32'h0000_BEEF, 4'h4, 4'b0011, 4'b0011, 14'd64,     32'hBEEF_BEEF};
    vecs[7] = '{3'b000, 32'h1000_FFFE, 32'h0000_005A, 4'h4, 4'b0100, 4'b0000, 14'h3FFF,   32'h5A5A_5A5A};
    vecs[8] = '{3'b010, 32'h2000_0008, 32'h0102_0304, 4'h1, 4'b0000, 4'b0000, 14'd2,      32'h0102_0304};

    // Reset state, with a live store and handshake inputs present.
    rst = 1'b1;
    drive(1'b1, 3'b010, 32'h3000_0010, 32'hDEAD_BEEF, 4'h4);
    uart_tx_ready = 1'b1;
    inst_retire   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_dmem_din", dmem_din, 32'd0);
    check("rst_imem_din", imem_din, 32'd0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_inst", inst_cnt, 32'd0);
    check("rst_err", 32'(st_err), 32'd0);

    // Counters: 100 cycles, retire on every other one, then MMIO counter reset.
    @(negedge clk);
    rst = 1'b0;
    idle();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      @(negedge clk);
    end
    #1;
    check("ctr_cycle_100", cycle_cnt, 32'd100);
    check("ctr_inst_50", inst_cnt, 32'd50);
    inst_retire = 1'b1;
    drive(1'b1, 3'b010, 32'h8000_0018, 32'h0, 4'h0);
    @(negedge clk);
    idle();
    #1;
    check("ctr_rst_cycle", cycle_cnt, 32'd0);
    check("ctr_rst_inst", inst_cnt, 32'd0);
    @(negedge clk);
    #1;
    check("ctr_resume_cycle", cycle_cnt, 32'd1);
    check("ctr_resume_inst", inst_cnt, 32'd1);
    inst_retire = 1'b0;

    run_table();

    // Misaligned SH: no lane writes, sticky error until reset.
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h1000_0001, 32'h0000_5555, 4'h4);
    #1;
    check("mis_dmem_we", 32'(dmem_we), 32'd0);
    check("mis_imem_we", 32'(imem_we), 32'd0);
    check("mis_err_before", 32'(st_err), 32'd0);
    @(negedge clk);
    idle();
    #1 check("mis_err_set", 32'(st_err), 32'd1);
    repeat (3) @(negedge clk);
    drive(1'b1, 3'b010, 32'h1000_0000, 32'h1, 4'h0);
    #1;
    check("mis_err_sticky", 32'(st_err), 32'd1);
    check("post_err_store_we", 32'(dmem_we), 32'd15);
    do_reset();
    #1 check("mis_err_cleared", 32'(st_err), 32'd0);

    // Illegal funct3 aimed at the UART: no load, no stall, error set.
    drive(1'b1, 3'b011, 32'h8000_0008, 32'h0000_0099, 4'h4);
    #1 check("ill_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("ill_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("ill_err", 32'(st_err), 32'd1);
    do_reset();

    // UART back-to-back stores with the receiver not ready.
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0041, 4'h0);
    #1 check("uart_first_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0042, 4'h0);
    #1;
    check("uart_first_valid", 32'(uart_tx_valid), 32'd1);
    check("uart_first_data", 32'(uart_tx_data), 32'h41);
    check("uart_second_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("uart_hold_stall", 32'(stall), 32'd1);
    check("uart_hold_data", 32'(uart_tx_data), 32'h41);
    uart_tx_ready = 1'b1;
    #1 check("uart_ready_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle();
    uart_tx_ready = 1'b0;
    #1;
    check("uart_refill_valid", 32'(uart_tx_valid), 32'd1);
    check("uart_refill_data", 32'(uart_tx_data), 32'h42);
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    #1 check("uart_drained", 32'(uart_tx_valid), 32'd0);

    // Reset in the middle of a pending byte drops it.
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0043, 4'h0);
    @(negedge clk);
    idle();
    #1;
    check("uart_pending_valid", 32'(uart_tx_valid), 32'd1);
    check("uart_pending_data", 32'(uart_tx_data), 32'h43);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("uart_rst_valid", 32'(uart_tx_valid), 32'd0);
    check("uart_rst_data", 32'(uart_tx_data), 32'd0);

    random_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
